decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 The module SHALL have parameter N, default 2, meaning select width in bits; legal range 1..6.
REQ-002 The module SHALL have parameter DWELL, default 4, meaning clock cycles each output stays active in scan mode; legal range 1..255.
REQ-003 The module SHALL derive M = 2**N, the output count; M is not a user parameter.
REQ-004 Port clk  input  1  the single clock; all state changes on the rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port en  input  1  block enable; low forces IDLE.
REQ-007 Port mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-008 Port load  input  1  single-cycle strobe that captures sel.
REQ-009 Port sel  input  N  requested output index.
REQ-010 Port d  output  M  registered one-hot decode; d[i] high selects index i.
REQ-011 Port valid  output  1  high when d holds a live one-hot code.
REQ-012 Port idx  output  N  registered binary index of the active d bit.
REQ-013 Port wrap  output  1  one-cycle pulse when scan advances from M-1 to 0.

Function
REQ-014 The block SHALL implement states IDLE, DIRECT and SCAN.
REQ-015 All outputs SHALL be registered, with d, idx and valid always mutually consistent: d == (1 << idx) when valid is 1, and d == 0 when valid is 0.
REQ-016 In IDLE: d=0, valid=0, idx=0, wrap=0.
REQ-017 IDLE to DIRECT SHALL occur on en=1, mode=0, load=1; the next cycle gives idx=sel and d=onehot(sel); latency is 1 cycle.
REQ-018 IDLE to SCAN SHALL occur on en=1, mode=1, regardless of load; the next cycle gives idx=sel, d=onehot(sel), and a dwell count of 0.
REQ-019 IDLE with en=1, mode=0, load=0 SHALL remain in IDLE.
REQ-020 In DIRECT, load=1 SHALL update idx and d to sel on the next cycle; with load=0 they hold.
REQ-021 In DIRECT, mode=1 SHALL move to SCAN, starting from the current idx with the dwell count cleared; if load=1 in the same cycle, the scan starts from sel.
REQ-022 In SCAN, an internal dwell counter SHALL count 0..DWELL-1; when it reaches DWELL-1, idx advances to (idx+1) mod M and the counter returns to 0.
REQ-023 With DWELL=1, idx SHALL advance every cycle.
REQ-024 wrap SHALL be 1 for exactly the cycle in which idx first shows 0 after M-1, and 0 otherwise, including on any load-forced move to 0.
REQ-025 In SCAN, load=1 SHALL restart the scan: idx=sel and the dwell count is cleared on the next cycle; load takes priority over a coincident advance.
REQ-026 In SCAN, mode=0 SHALL move to DIRECT, freezing the current idx; if load=1 in the same cycle, it moves to sel instead.
REQ-027 en=0 in any state SHALL return to IDLE on the next edge, overriding mode and load.
REQ-028 When N=1, M=2 and scan SHALL alternate d between 01 and 10.
REQ-029 The dwell counter width SHALL be ceil(log2(DWELL+1)) bits and SHALL not overflow.

Reset
REQ-030 rst=1 SHALL immediately, without waiting for clk, force state IDLE, d=0, idx=0, valid=0, wrap=0, and dwell count 0.
REQ-031 Reset asserted mid-scan SHALL discard all progress; after release, the block stays in IDLE until the REQ-017 or REQ-018 entry conditions hold.
REQ-032 Release of reset SHALL be sampled synchronously; the first state change is possible at the first rising edge after release.

Verification (N=2, DWELL=3 unless stated)
REQ-033 Reset: rst=1 mid-operation, no clk edge -> d=0000, valid=0, idx=0, wrap=0 immediately.
REQ-034 Direct sweep: en=1, mode=0, load pulsed with sel=0,1,2,3 -> one cycle later d=0001, 0010, 0100, 1000 and valid=1.
REQ-035 Scan wrap: en=1, mode=1, sel=2 -> d=0100 for 3 cycles, then 1000 for 3 cycles, then 0001 with wrap=1 for one cycle only.
REQ-036 Load in scan: during SCAN at idx=1 with dwell=2, load=1 and sel=3 -> next cycle idx=3, dwell restarts, no advance to 2, wrap=0.
REQ-037 Enable drop: en=0 during SCAN or DIRECT -> next cycle d=0000, valid=0; en=1, mode=0, load=0 -> stays IDLE.
REQ-038 DWELL=1, N=1 with mode=1 -> d alternates 01/10 every cycle, and wrap pulses on each 0 entry after 1.

Source files
------------

// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder with a direct-select mode and an
// auto-scan mode that steps through every output, holding each for DWELL
// cycles. d, idx and valid are produced from the same next-state values, so
// they can never disagree.
module decoder_scan #(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              load,
    input  logic [N-1:0]      sel,
    output logic [2**N-1:0]   d,
    output logic              valid,
    output logic [N-1:0]      idx,
    output logic              wrap
);

    localparam int M  = 2 ** N;
    localparam int CW = $clog2(DWELL + 1);

    localparam logic [N-1:0]  IDX_MAX  = N'(M - 1);
    localparam logic [N-1:0]  IDX_ONE  = N'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [M-1:0]  D_ONE    = M'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    idx_q,   idx_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            wrap_q,  wrap_d;
    logic            valid_q, valid_d;
    logic [M-1:0]    d_q,     d_d;

    // Next-state and next-output logic; en low overrides everything.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;

        if (!en) begin
            state_d = S_IDLE;
            idx_d   = {N{1'b0}};
            cnt_d   = {CW{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mode) begin
                        state_d = S_SCAN;
                        idx_d   = sel;
                        cnt_d   = {CW{1'b0}};
                    end else if (load) begin
                        state_d = S_DIRECT;
                        idx_d   = sel;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        idx_d   = {N{1'b0}};
                        cnt_d   = {CW{1'b0}};
                    end
                end
                S_DIRECT: begin
                    // The dwell count is parked at zero so a later scan
                    // entry always starts a full dwell period.
                    cnt_d = {CW{1'b0}};
                    if (load) begin
                        idx_d = sel;
                    end else begin
                        idx_d = idx_q;
                    end
                    if (mode) begin
                        state_d = S_SCAN;
                    end else begin
                        state_d = S_DIRECT;
                    end
                end
                S_SCAN: begin
                    if (!mode) begin
                        state_d = S_DIRECT;
                        cnt_d   = {CW{1'b0}};
                        if (load) begin
                            idx_d = sel;
                        end else begin
                            idx_d = idx_q;
                        end
                    end else if (load) begin
                        // A restart wins over a coincident advance and never
                        // reports a wrap, even when sel is zero.
                        idx_d = sel;
                        cnt_d = {CW{1'b0}};
                    end else if (cnt_q == CNT_LAST) begin
                        idx_d  = idx_q + IDX_ONE;
                        cnt_d  = {CW{1'b0}};
                        wrap_d = (idx_q == IDX_MAX);
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = {N{1'b0}};
                    cnt_d   = {CW{1'b0}};
                end
            endcase
        end

        valid_d = (state_d != S_IDLE);
        if (valid_d) begin
            d_d = D_ONE << idx_d;
        end else begin
            d_d = {M{1'b0}};
        end
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= {N{1'b0}};
            cnt_q   <= {CW{1'b0}};
            wrap_q  <= 1'b0;
            valid_q <= 1'b0;
            d_q     <= {M{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            valid_q <= valid_d;
            d_q     <= d_d;
        end
    end

    assign d     = d_q;
    assign valid = valid_q;
    assign idx   = idx_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: instance A (N=2, DWELL=3) and instance B
// (N=1, DWELL=1) share stimulus. A stimulus process pushes the expected
// output of each cycle into per-instance queues; a monitor pops and compares
// after every rising edge.
module tb_decoder_scan;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       en   = 1'b0;
    logic       mode = 1'b0;
    logic       load = 1'b0;
    logic [1:0] sel  = 2'd0;
    logic [0:0] sel_b;

    logic [3:0] d_a;
    logic       valid_a;
    logic [1:0] idx_a;
    logic       wrap_a;
    logic [1:0] d_b;
    logic       valid_b;
    logic [0:0] idx_b;
    logic       wrap_b;

    assign sel_b = sel[0:0];

    decoder_scan #(.N(2), .DWELL(3)) u_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel),
        .d(d_a), .valid(valid_a), .idx(idx_a), .wrap(wrap_a)
    );

    decoder_scan #(.N(1), .DWELL(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel_b),
        .d(d_b), .valid(valid_b), .idx(idx_b), .wrap(wrap_b)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    // Reference model: mode 0=idle 1=direct 2=scan, cycles left at idx.
    int st[2];
    int ix[2];
    int left[2];
    int wr[2];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            st[k] = 0; ix[k] = 0; left[k] = 0; wr[k] = 0;
        end
    endtask

    task automatic mstep(input int k, input int mm, input int dw,
                         input bit e, input bit mo, input bit ld, input int s);
        wr[k] = 0;
        if (!e) begin
            st[k] = 0; ix[k] = 0;
        end else begin
            case (st[k])
                0: begin
                    if (mo) begin
                        st[k] = 2; ix[k] = s; left[k] = dw;
                    end else if (ld) begin
                        st[k] = 1; ix[k] = s;
                    end
                end
                1: begin
                    if (ld) ix[k] = s;
                    if (mo) begin
                        st[k] = 2; left[k] = dw;
                    end
                end
                2: begin
                    if (!mo) begin
                        st[k] = 1;
                        if (ld) ix[k] = s;
                    end else if (ld) begin
                        ix[k] = s; left[k] = dw;
                    end else begin
                        left[k]--;
                        if (left[k] == 0) begin
                            ix[k] = (ix[k] + 1) % mm;
                            left[k] = dw;
                            wr[k] = (ix[k] == 0) ? 1 : 0;
                        end
                    end
                end
                default: st[k] = 0;
            endcase
        end
    endtask

    function automatic logic [7:0] pk(input int k);
        int v;
        int dd;
        v  = (st[k] != 0) ? 1 : 0;
        dd = (v != 0) ? (1 << ix[k]) : 0;
        if (k == 0) return 8'(dd * 16 + v * 8 + ix[k] * 2 + wr[k]);
        else        return 8'(dd * 8 + v * 4 + ix[k] * 2 + wr[k]);
    endfunction

    task automatic push_exp();
        qa.push_back(pk(0));
        qb.push_back(pk(1));
    endtask

    task automatic step(input bit r, input bit e, input bit mo, input bit ld, input logic [1:0] s);
        @(negedge clk);
        rst = r; en = e; mode = mo; load = ld; sel = s;
        if (r) begin
            mreset();
        end else begin
            mstep(0, 4, 3, e, mo, ld, int'(s));
            mstep(1, 2, 1, e, mo, ld, int'(s[0]));
        end
        push_exp();
    endtask

    // Raise rst between edges and confirm outputs clear without a clock.
    task automatic mid_reset(input string name);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check({name, "_a"}, {d_a, valid_a, idx_a, wrap_a}, 8'h00);
        check({name, "_b"}, {3'b000, d_b, valid_b, idx_b, wrap_b}, 8'h00);
        mreset();
        push_exp();
    endtask

    // Monitor: after every rising edge compare DUT outputs with the queue head.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("out_a", {d_a, valid_a, idx_a, wrap_a}, e);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("out_b", {3'b000, d_b, valid_b, idx_b, wrap_b}, e);
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        bit cur_mode;
        bit r;
        bit e;
        bit ld;
        mreset();
        #2 rst = 1'b1;
        #1;
        check("rst_init_a", {d_a, valid_a, idx_a, wrap_a}, 8'h00);
        check("rst_init_b", {3'b000, d_b, valid_b, idx_b, wrap_b}, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'd3);
        // Idle with en=1, mode=0, load=0 must stay idle.
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        // Direct sweep.
        for (int s = 0; s < 4; s++) step(1'b0, 1'b1, 1'b0, 1'b1, 2'(s));
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        // Enable drop from direct, then idle hold.
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        // Scan from 2 through the wrap.
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 2'd2);
        // Enable drop from scan.
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        // Load in scan at idx=1, dwell=2.
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        // Load of 0 during scan must not wrap.
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
        // Scan to direct freeze, direct to scan resume, scan to direct with load.
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        // Asynchronous reset mid-scan, then idle until entry conditions.
        mid_reset("async_rst");
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd3);
        // Randomized traffic.
        cur_mode = 1'b1;
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            e  = ($urandom_range(0, 24) != 0);
            ld = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 9) == 0) cur_mode = ~cur_mode;
            step(r, e, cur_mode, ld, 2'($urandom_range(0, 3)));
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        // Let the monitor drain, bounded.
        for (int i = 0; i < 10; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(posedge clk);
            #2;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
